// File: rtl/psola_pkg.sv
// psola_pkg: shared state encoding and default sizing for the PSOLA scheduler
package psola_pkg;
  typedef enum logic [1:0] {
    WAIT_WINDOW,
    WAIT_TAU,
    BURST,
    WAIT_PSOLA
  } sched_state_e;
  localparam int DEF_WINDOW_SIZE        = 2048;
  localparam int DEF_BURST_PERIOD       = 5;
  localparam int DEF_SAMP_PLAY_DURATION = 2304;
  localparam int DEF_TAU_WIDTH          = 11;
endpackage

// File: rtl/pipeline.sv
// pipeline: fixed-latency register chain with synchronous clear
module pipeline #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
)(
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);
  logic [WIDTH-1:0] stage_q [STAGES];
  always_ff @(posedge clk_in) begin
    stage_q[0] <= rst_in ? '0 : data_in;
    for (int i = 1; i < STAGES; i++) stage_q[i] <= rst_in ? '0 : stage_q[i-1];
  end
  assign data_out = stage_q[STAGES-1];
endmodule

// File: rtl/psola_scheduler_rate_pacer.sv
// rate_pacer: while enabled, counts 0..PERIOD-1 and pulses on the last count
module rate_pacer import psola_pkg::*; #(
  parameter int PERIOD = DEF_BURST_PERIOD
)(
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic pulse_out
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (!en_in || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk_in) cnt_q <= rst_in ? '0 : cnt_d;
  assign pulse_out = en_in && cnt_q == LAST;
endmodule

// File: rtl/psola_scheduler.sv
// psola_scheduler: per-window sequencing of YIN, burst read-out and playback pacing
module psola_scheduler import psola_pkg::*; #(
  parameter int WINDOW_SIZE        = DEF_WINDOW_SIZE,
  parameter int BURST_PERIOD       = DEF_BURST_PERIOD,
  parameter int SAMP_PLAY_DURATION = DEF_SAMP_PLAY_DURATION,
  parameter int TAU_WIDTH          = DEF_TAU_WIDTH
)(
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           sample_valid_in,
  output logic                           yin_start_out,
  input  logic [TAU_WIDTH-1:0]           taumin_in,
  input  logic                           taumin_valid_in,
  output logic [TAU_WIDTH-1:0]           tau_out,
  output logic                           tau_valid_out,
  output logic                           burst_trigger_out,
  output logic [$clog2(WINDOW_SIZE)-1:0] burst_addr_piped_out,
  input  logic                           psola_done_in,
  output logic                           play_trigger_out,
  output logic                           playing_out,
  output logic                           overrun_out,
  output logic                           busy_out
);
  localparam int AW = $clog2(WINDOW_SIZE);
  localparam logic [AW-1:0] LAST_IDX = AW'(WINDOW_SIZE - 1);
  sched_state_e state_q, state_d;
  logic [AW-1:0] samp_cnt_q, samp_cnt_d, burst_addr_q, burst_addr_d;
  logic [TAU_WIDTH-1:0] tau_q, tau_d;
  logic yin_start_q, yin_start_d, tau_valid_q, tau_valid_d;
  logic overrun_q, overrun_d, playing_q, playing_d;
  logic win_done, done_ok, burst_last;
  assign win_done   = sample_valid_in && samp_cnt_q == LAST_IDX;
  assign done_ok    = state_q == WAIT_PSOLA && psola_done_in;
  assign burst_last = burst_trigger_out && burst_addr_q == LAST_IDX;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= WAIT_WINDOW;
      samp_cnt_q   <= '0;
      burst_addr_q <= '0;
      tau_q        <= '0;
      yin_start_q  <= 1'b0;
      tau_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      playing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      samp_cnt_q   <= samp_cnt_d;
      burst_addr_q <= burst_addr_d;
      tau_q        <= tau_d;
      yin_start_q  <= yin_start_d;
      tau_valid_q  <= tau_valid_d;
      overrun_q    <= overrun_d;
      playing_q    <= playing_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_WINDOW: state_d = win_done ? WAIT_TAU : WAIT_WINDOW;
      WAIT_TAU:    state_d = taumin_valid_in ? BURST : WAIT_TAU;
      BURST:       state_d = burst_last ? WAIT_PSOLA : BURST;
      WAIT_PSOLA:  state_d = psola_done_in ? (win_done ? WAIT_TAU : WAIT_WINDOW) : WAIT_PSOLA;
      default:     state_d = WAIT_WINDOW;
    endcase
  end
  // A window landing on the psola_done cycle is taken, not dropped
  always_comb begin
    samp_cnt_d   = samp_cnt_q + AW'(sample_valid_in);
    yin_start_d  = win_done && (state_q == WAIT_WINDOW || done_ok);
    overrun_d    = win_done && !yin_start_d;
    tau_valid_d  = state_q == WAIT_TAU && taumin_valid_in;
    tau_d        = tau_valid_d ? taumin_in : tau_q;
    burst_addr_d = burst_last ? '0 : burst_trigger_out ? burst_addr_q + AW'(1) : burst_addr_q;
    playing_d    = playing_q || done_ok;
  end
  rate_pacer #(.PERIOD(BURST_PERIOD)) u_burst_pacer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (state_q == BURST),
    .pulse_out (burst_trigger_out)
  );
  rate_pacer #(.PERIOD(SAMP_PLAY_DURATION)) u_play_pacer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (playing_q),
    .pulse_out (play_trigger_out)
  );
  pipeline #(.WIDTH(AW), .STAGES(2)) u_addr_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (burst_addr_q),
    .data_out (burst_addr_piped_out)
  );
  assign yin_start_out = yin_start_q;
  assign tau_out       = tau_q;
  assign tau_valid_out = tau_valid_q;
  assign overrun_out   = overrun_q;
  assign playing_out   = playing_q;
  assign busy_out      = state_q != WAIT_WINDOW;
endmodule

// File: doc/psola_scheduler.md
# psola_scheduler

Per-window sequencer for the pitch-correction datapath. Counts incoming audio samples into fixed windows, kicks off YIN analysis, forwards the resulting tau to the PSOLA engine, paces the burst read-out of the input ring buffer into PSOLA, and drives the fixed-rate playback reads from the output ring buffer. It sits between the sample source, the YIN core, the input/output ring buffers and the PSOLA BRAM wrapper, and owns all of their trigger timing.

## Interface
- WINDOW_SIZE, 2048, samples per analysis window and per burst (power of two)
- BURST_PERIOD, 5, clock cycles between successive burst read triggers (≥2)
- SAMP_PLAY_DURATION, 2304, clock cycles between playback read triggers
- TAU_WIDTH, 11, width of tau
- clk_in  in  1  single system clock
- rst_in  in  1  synchronous, active-high reset
- sample_valid_in  in  1  one new input sample accepted this cycle
- yin_start_out  out  1  one-cycle pulse: window complete, start YIN
- taumin_in  in  TAU_WIDTH  YIN result
- taumin_valid_in  in  1  taumin_in valid (one-cycle pulse)
- tau_out  out  TAU_WIDTH  latched tau for PSOLA
- tau_valid_out  out  1  one-cycle pulse: tau_out updated
- burst_trigger_out  out  1  read trigger to input ring buffer
- burst_addr_piped_out  out  $clog2(WINDOW_SIZE)  burst address delayed 2 cycles, aligned with ring-buffer read data
- psola_done_in  in  1  PSOLA finished current window (pulse)
- play_trigger_out  out  1  read trigger to output ring buffer
- playing_out  out  1  playback pacer running
- overrun_out  out  1  one-cycle pulse: window completed while busy, window dropped
- busy_out  out  1  state ≠ WAIT_WINDOW

## Operation
- Sample counter: 0..WINDOW_SIZE-1, increments on sample_valid_in, wraps to 0; free-running in all states. Window completes on the sample_valid_in cycle where counter == WINDOW_SIZE-1.
- States: WAIT_WINDOW, WAIT_TAU, BURST, WAIT_PSOLA.
- WAIT_WINDOW: window complete → yin_start_out next cycle, go WAIT_TAU.
- WAIT_TAU: taumin_valid_in → tau_out <= taumin_in, tau_valid_out pulse next cycle, go BURST with burst_hold=0, burst_addr=0.
- BURST: burst_hold counts 0..BURST_PERIOD-1; burst_trigger_out = (burst_hold == BURST_PERIOD-1). On each trigger burst_addr increments; on trigger with burst_addr == WINDOW_SIZE-1 go WAIT_PSOLA, burst_addr <= 0. Exactly WINDOW_SIZE triggers per burst.
- WAIT_PSOLA: psola_done_in → go WAIT_WINDOW; first accepted psola_done_in after reset sets playing_out.
- Window completion in any state other than WAIT_WINDOW → overrun_out pulse, no yin_start_out, window dropped. Exception: window completion in the same cycle as an accepted psola_done_in is accepted (yin_start_out issued, go WAIT_TAU directly, no overrun).
- taumin_valid_in outside WAIT_TAU and psola_done_in outside WAIT_PSOLA ignored.
- Playback pacer: once playing_out = 1, counter 0..SAMP_PLAY_DURATION-1 free-running; play_trigger_out high while counter == SAMP_PLAY_DURATION-1. Never stops until reset.

## Timing
- Reset values: all outputs 0, tau_out 0, state WAIT_WINDOW, all counters 0, playing_out 0.
- Reset mid-burst or mid-playback: everything returns to reset values next cycle; no further triggers.
- yin_start_out: cycle N+1 for completing sample at N.
- tau_valid_out/tau_out: cycle N+1 for taumin_valid_in at N; first burst_trigger_out at N+BURST_PERIOD.
- Burst length: WINDOW_SIZE*BURST_PERIOD cycles from entering BURST to entering WAIT_PSOLA.
- burst_addr_piped_out: value of burst_addr at its trigger, appearing 2 cycles later.
- playing_out rises cycle T+1 for psola_done_in at T; first play_trigger_out at T+SAMP_PLAY_DURATION, then every SAMP_PLAY_DURATION cycles.
- All outputs registered except burst_trigger_out and play_trigger_out (decoded from registered counters).

## Structure
- psola_pkg: sched_state_e enum, default constants for WINDOW_SIZE, BURST_PERIOD, SAMP_PLAY_DURATION.
- Sub-module rate_pacer (enable, period parameter, counter, pulse at period-1), instanced for burst pacing and playback pacing.
- burst address delay uses the existing pipeline module, STAGES=2.

## Test plan
Use WINDOW_SIZE=8, BURST_PERIOD=3, SAMP_PLAY_DURATION=10.
- 8 sample_valid_in pulses → one yin_start_out one cycle after the 8th; 7 pulses → none.
- taumin_valid_in with taumin_in=300 at cycle N → tau_out=300, tau_valid_out at N+1; burst_trigger_out at N+3, N+6, …, N+24 (8 triggers), burst_addr_piped_out 0..7 each 2 cycles after its trigger.
- 8 more samples during BURST → overrun_out pulse, no yin_start_out, state stays BURST.
- psola_done_in at T in WAIT_PSOLA → playing_out at T+1, play_trigger_out at T+10, T+20, T+30.
- Window completion and psola_done_in same cycle → yin_start_out next cycle, no overrun_out.
- rst_in mid-burst → next cycle no triggers, tau_out=0, playing_out=0; subsequent 8 samples restart normally.
